// File: rtl/puf_challenge_sequencer_if.sv
// rtl/puf_challenge_sequencer_if.sv - result handshake bundle between the PUF sequencer and its consumer
//
// Carries one challenge/response pair per RES_VALID/RES_READY handshake.
//   RES_VALID      producer -> consumer  pair available
//   RES_READY      consumer -> producer  pair accepted on a clock edge with RES_VALID high
//   RES_CHALLENGE  producer -> consumer  challenge of the presented pair
//   RES_DATA       producer -> consumer  captured response (0 on timeout)
//   RES_TIMEOUT    producer -> consumer  PUF never signalled DONE for this challenge
interface puf_challenge_sequencer_if #(
  parameter int CW = 8,
  parameter int RW = 8
);
  logic          RES_VALID;
  logic          RES_READY;
  logic [CW-1:0] RES_CHALLENGE;
  logic [RW-1:0] RES_DATA;
  logic          RES_TIMEOUT;

  modport master (
    output RES_VALID,
    output RES_CHALLENGE,
    output RES_DATA,
    output RES_TIMEOUT,
    input  RES_READY
  );

  modport slave (
    input  RES_VALID,
    input  RES_CHALLENGE,
    input  RES_DATA,
    input  RES_TIMEOUT,
    output RES_READY
  );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// rtl/puf_challenge_sequencer.sv - sweeps a challenge range through an RO PUF and streams the results
//
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   START, FIRST, LAST    sweep request and inclusive range (sampled on accepted START)
//   PUF_RESET, PUF_CHALLENGE, PUF_RESPONSE, PUF_DONE
//                         initiator side of the RO PUF
//   res                   result handshake (master side)
//   BUSY, SWEEP_DONE      sweep in progress / one-cycle pulse after the last result is taken
module puf_challenge_sequencer #(
  parameter int CW             = 8,
  parameter int RW             = 8,
  parameter int ARM_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        START,
  input  logic [CW-1:0]               FIRST,
  input  logic [CW-1:0]               LAST,
  output logic                        PUF_RESET,
  output logic [CW-1:0]               PUF_CHALLENGE,
  input  logic [RW-1:0]               PUF_RESPONSE,
  input  logic                        PUF_DONE,
  puf_challenge_sequencer_if.master   res,
  output logic                        BUSY,
  output logic                        SWEEP_DONE
);

  localparam int AW = $clog2(ARM_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SETTLE,
    S_WAIT,
    S_CAPTURE,
    S_PRESENT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cur_q, cur_d;
  logic [CW-1:0] end_q, end_d;
  logic [AW-1:0] arm_q, arm_d;
  logic [TW-1:0] to_q, to_d;
  logic [CW-1:0] res_chal_q, res_chal_d;
  logic [RW-1:0] res_data_q, res_data_d;
  logic          res_to_q, res_to_d;
  logic          sweep_done_q, sweep_done_d;
  logic          puf_reset;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      end_q        <= '0;
      arm_q        <= '0;
      to_q         <= '0;
      res_chal_q   <= '0;
      res_data_q   <= '0;
      res_to_q     <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      end_q        <= end_d;
      arm_q        <= arm_d;
      to_q         <= to_d;
      res_chal_q   <= res_chal_d;
      res_data_q   <= res_data_d;
      res_to_q     <= res_to_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    end_d        = end_q;
    arm_d        = arm_q;
    to_d         = to_q;
    res_chal_d   = res_chal_q;
    res_data_d   = res_data_q;
    res_to_d     = res_to_q;
    sweep_done_d = 1'b0;
    puf_reset    = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          cur_d   = FIRST;
          end_d   = LAST;
          arm_d   = '0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (arm_q == ARM_LAST) begin
          state_d = S_SETTLE;
        end else begin
          arm_d = arm_q + AW'(1);
        end
      end
      S_SETTLE: begin
        // DONE may still be high from the previous challenge; it is not looked at here.
        puf_reset = 1'b0;
        to_d      = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        puf_reset = 1'b0;
        // DONE is tested first so a completion on the expiry cycle still counts.
        if (PUF_DONE) begin
          state_d = S_CAPTURE;
        end else if (to_q == TO_LAST) begin
          res_chal_d = cur_q;
          res_data_d = '0;
          res_to_d   = 1'b1;
          state_d    = S_PRESENT;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_CAPTURE: begin
        puf_reset  = 1'b0;
        res_chal_d = cur_q;
        res_data_d = PUF_RESPONSE;
        res_to_d   = 1'b0;
        state_d    = S_PRESENT;
      end
      S_PRESENT: begin
        if (res.RES_READY) begin
          if (cur_q == end_q) begin
            sweep_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            // Wraps through the top of the challenge space when FIRST > LAST.
            cur_d   = cur_q + CW'(1);
            arm_d   = '0;
            state_d = S_ARM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign PUF_RESET         = puf_reset;
  assign PUF_CHALLENGE     = cur_q;
  assign BUSY              = (state_q != S_IDLE);
  assign SWEEP_DONE        = sweep_done_q;
  assign res.RES_VALID     = (state_q == S_PRESENT);
  assign res.RES_CHALLENGE = res_chal_q;
  assign res.RES_DATA      = res_data_q;
  assign res.RES_TIMEOUT   = res_to_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb/tb_puf_challenge_sequencer.sv - randomized self-checking bench for puf_challenge_sequencer
module tb_puf_challenge_sequencer;

  localparam int CW      = 8;
  localparam int RW      = 8;
  localparam int ARM     = 4;
  localparam int TIMEOUT = 100;

  logic          CLK;
  logic          RESET;
  logic          START;
  logic [CW-1:0] FIRST;
  logic [CW-1:0] LAST;
  logic          PUF_RESET;
  logic [CW-1:0] PUF_CHALLENGE;
  logic [RW-1:0] PUF_RESPONSE;
  logic          PUF_DONE;
  logic          BUSY;
  logic          SWEEP_DONE;

  puf_challenge_sequencer_if #(.CW(CW), .RW(RW)) res_if ();

  puf_challenge_sequencer #(
    .CW(CW), .RW(RW), .ARM_CYCLES(ARM), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .START(START),
    .FIRST(FIRST),
    .LAST(LAST),
    .PUF_RESET(PUF_RESET),
    .PUF_CHALLENGE(PUF_CHALLENGE),
    .PUF_RESPONSE(PUF_RESPONSE),
    .PUF_DONE(PUF_DONE),
    .res(res_if.master),
    .BUSY(BUSY),
    .SWEEP_DONE(SWEEP_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // PUF model: DONE rises once more than delay_tab[challenge] cycles have passed since
  // reset fell; stale_en adds a bogus DONE (response 0xAA) on the first cycle after the fall.
  int          delay_tab [256];
  bit          stale_en  = 0;
  int          puf_cnt   = 0;
  int          ready_pct = 100;
  logic [16:0] exp_q [$];
  int          sweep_cnt = 0;
  int          accepted  = 0;
  bit          pending   = 0;
  bit          prev_sd   = 0;
  logic [16:0] held;

  always @(negedge CLK) begin
    if (PUF_RESET) begin
      puf_cnt      = 0;
      PUF_DONE     = 1'b0;
      PUF_RESPONSE = '0;
    end else begin
      puf_cnt++;
      if (puf_cnt > delay_tab[PUF_CHALLENGE]) begin
        PUF_DONE     = 1'b1;
        PUF_RESPONSE = ~PUF_CHALLENGE;
      end else if (stale_en && puf_cnt == 1) begin
        PUF_DONE     = 1'b1;
        PUF_RESPONSE = 8'hAA;
      end else begin
        PUF_DONE     = 1'b0;
        PUF_RESPONSE = '0;
      end
    end

    res_if.RES_READY = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);

    if (RESET) begin
      pending = 0;
      prev_sd = 0;
    end else begin
      if (pending) begin
        check_eq("valid_held", res_if.RES_VALID, 1'b1);
        check_eq("payload_held", {res_if.RES_TIMEOUT, res_if.RES_CHALLENGE, res_if.RES_DATA}, held);
      end
      held    = {res_if.RES_TIMEOUT, res_if.RES_CHALLENGE, res_if.RES_DATA};
      pending = res_if.RES_VALID && !res_if.RES_READY;
      if (res_if.RES_VALID && res_if.RES_READY) begin
        accepted++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_result", {res_if.RES_TIMEOUT, res_if.RES_CHALLENGE, res_if.RES_DATA}, 17'h1FFFF);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check_eq("res_challenge", res_if.RES_CHALLENGE, e[15:8]);
          check_eq("res_data", res_if.RES_DATA, e[7:0]);
          check_eq("res_timeout", res_if.RES_TIMEOUT, e[16]);
        end
      end
      if (SWEEP_DONE) begin
        sweep_cnt++;
        check_eq("sweep_done_all_taken", exp_q.size(), 0);
        check_eq("sweep_done_busy", BUSY, 1'b0);
        check_eq("sweep_done_single_cycle", prev_sd, 1'b0);
      end
      prev_sd = SWEEP_DONE;
    end
  end

  task automatic fill_delays(input int lo, input int hi);
    for (int i = 0; i < 256; i++) delay_tab[i] = $urandom_range(lo, hi);
  endtask

  // Expected sequence computed from the range rules: count = ((LAST-FIRST) mod 256) + 1.
  function automatic int build_expected(input logic [7:0] f, input logic [7:0] l);
    int n;
    n = ((int'(l) - int'(f) + 256) % 256) + 1;
    for (int i = 0; i < n; i++) begin
      logic [7:0] c;
      bit         to;
      c  = 8'((int'(f) + i) % 256);
      to = delay_tab[c] > TIMEOUT;
      exp_q.push_back({to, c, to ? 8'h00 : ~c});
    end
    return n;
  endfunction

  task automatic pulse_start(input logic [7:0] f, input logic [7:0] l, output int lat);
    @(negedge CLK);
    FIRST = f;
    LAST  = l;
    START = 1'b1;
    lat   = 0;
    do begin
      @(negedge CLK);
      START = 1'b0;
      lat++;
    end while (PUF_RESET && lat < 50);
    FIRST = 8'($urandom);
    LAST  = 8'($urandom);
  endtask

  task automatic run_sweep(input logic [7:0] f, input logic [7:0] l, input int pct);
    int n, base, lat, cyc;
    n         = build_expected(f, l);
    ready_pct = pct;
    base      = sweep_cnt;
    pulse_start(f, l, lat);
    check_eq("start_to_reset_fall", lat, ARM + 1);
    cyc = 0;
    while (sweep_cnt == base && cyc < n * 400 + 100) begin
      @(negedge CLK);
      cyc++;
    end
    @(negedge CLK);
    check_eq("sweep_count", sweep_cnt - base, 1);
    check_eq("results_left", exp_q.size(), 0);
    check_eq("idle_busy", BUSY, 1'b0);
    check_eq("idle_puf_reset", PUF_RESET, 1'b1);
    exp_q.delete();
  endtask

  task automatic check_reset_values();
    check_eq("rst_puf_reset", PUF_RESET, 1'b1);
    check_eq("rst_puf_challenge", PUF_CHALLENGE, 8'h00);
    check_eq("rst_res_valid", res_if.RES_VALID, 1'b0);
    check_eq("rst_res_challenge", res_if.RES_CHALLENGE, 8'h00);
    check_eq("rst_res_data", res_if.RES_DATA, 8'h00);
    check_eq("rst_res_timeout", res_if.RES_TIMEOUT, 1'b0);
    check_eq("rst_busy", BUSY, 1'b0);
    check_eq("rst_sweep_done", SWEEP_DONE, 1'b0);
  endtask

  initial begin
    int          cyc, lat, sd_before;
    logic [7:0]  chal_before;

    RESET            = 1'b1;
    START            = 1'b0;
    FIRST            = '0;
    LAST             = '0;
    PUF_DONE         = 1'b0;
    PUF_RESPONSE     = '0;
    res_if.RES_READY = 1'b0;
    for (int i = 0; i < 256; i++) delay_tab[i] = 50;

    repeat (3) @(negedge CLK);
    check_reset_values();
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Basic ascending range, DONE after 50 cycles.
    run_sweep(8'h10, 8'h13, 100);

    // Wrapping range.
    fill_delays(1, 40);
    run_sweep(8'hFE, 8'h01, 100);

    // Challenge 0x05 never completes.
    fill_delays(5, 30);
    delay_tab[5] = 100000;
    run_sweep(8'h04, 8'h06, 100);

    // DONE in the last WAIT cycle, and one cycle too late.
    delay_tab[8'h20] = TIMEOUT - 1;
    delay_tab[8'h21] = TIMEOUT;
    delay_tab[8'h22] = TIMEOUT + 1;
    run_sweep(8'h20, 8'h22, 100);

    // Back-pressure from a sluggish consumer.
    fill_delays(1, 60);
    run_sweep(8'h30, 8'h3B, 30);

    // Stale DONE lingering into the first cycle after reset fall.
    stale_en = 1;
    fill_delays(5, 20);
    run_sweep(8'h40, 8'h43, 100);
    stale_en = 0;

    // Single-challenge range, random ready.
    run_sweep(8'h77, 8'h77, 50);

    // Full challenge space.
    fill_delays(2, 6);
    run_sweep(8'h00, 8'hFF, 100);

    // Reset mid-sweep with an ignored START first.
    for (int i = 0; i < 256; i++) delay_tab[i] = 50;
    ready_pct = 100;
    void'(build_expected(8'h00, 8'h0F));
    accepted  = 0;
    pulse_start(8'h00, 8'h0F, lat);
    cyc = 0;
    while ((accepted < 2 || PUF_RESET) && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
    end
    check_eq("reached_wait", PUF_RESET, 1'b0);
    chal_before = PUF_CHALLENGE;
    @(negedge CLK);
    FIRST = 8'h80;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check_eq("busy_start_ignored_chal", PUF_CHALLENGE, chal_before);
    check_eq("busy_start_ignored_busy", BUSY, 1'b1);
    sd_before = sweep_cnt;
    #2 RESET = 1'b1;
    #1 check_reset_values();
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge CLK);
    check_eq("no_sweep_done_after_reset", sweep_cnt, sd_before);
    check_eq("idle_after_reset", BUSY, 1'b0);
    run_sweep(8'h50, 8'h52, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got 0x1 expected 0x0");
    $fatal(1);
  end

endmodule

// File: doc/puf_challenge_sequencer.md
Name: puf_challenge_sequencer

Overview:
Initiator side of the RO PUF challenge/response interface. It sweeps an inclusive challenge range and drives each challenge into the PUF. For each challenge it pulses the PUF reset, waits for DONE with a timeout, and captures the response. Each challenge/response pair is then presented on a valid/ready result port for the display or UART logic. It sits between the board-level top and the RO_PUF instance, replacing the direct SWITCHES-to-CHALLENGE wiring.

Parameters:
CW, 8, challenge width in bits
RW, 8, response width in bits
ARM_CYCLES, 4, cycles PUF_RESET is held high per challenge (>=1)
TIMEOUT_CYCLES, 1000000, maximum WAIT cycles before a timeout is declared (>=2)

Ports:
CLK  input  1  system clock; all logic on rising edge
RESET  input  1  asynchronous, active-high reset
START  input  1  single-cycle pulse that begins a sweep; ignored while BUSY=1
FIRST  input  CW  first challenge, sampled on accepted START
LAST  input  CW  last challenge (inclusive), sampled on accepted START
PUF_RESET  output  1  reset to the RO_PUF
PUF_CHALLENGE  output  CW  challenge to the RO_PUF; held stable from ARM through CAPTURE
PUF_RESPONSE  input  RW  response from the RO_PUF
PUF_DONE  input  1  RO_PUF completion level; high while the response is valid, cleared by PUF_RESET
RES_VALID  output  1  result pair available
RES_READY  input  1  consumer accepts the result when RES_VALID and RES_READY are both high on a clock edge
RES_CHALLENGE  output  CW  challenge of the presented result
RES_DATA  output  RW  captured response; 0 when RES_TIMEOUT=1
RES_TIMEOUT  output  1  PUF did not assert DONE within TIMEOUT_CYCLES
BUSY  output  1  high in every state except IDLE
SWEEP_DONE  output  1  one-cycle pulse after the final result is accepted

Behaviour:
- Reset values (asynchronous): state=IDLE, PUF_RESET=1 (PUF held in reset while idle), PUF_CHALLENGE=0, RES_VALID=0, RES_CHALLENGE=0, RES_DATA=0, RES_TIMEOUT=0, BUSY=0, SWEEP_DONE=0, all counters=0.
- IDLE: PUF_RESET=1.
  - On START: latch cur=FIRST and end=LAST, set PUF_CHALLENGE=FIRST, go to ARM.
- ARM: PUF_RESET=1 for exactly ARM_CYCLES cycles, then go to SETTLE.
- SETTLE: PUF_RESET=0 for one cycle; PUF_DONE is ignored here to block a stale DONE. Clear the timeout counter, go to WAIT.
- WAIT: PUF_RESET=0; the timeout counter increments every cycle.
  - PUF_DONE=1: go to CAPTURE.
  - Counter reaches TIMEOUT_CYCLES-1 with PUF_DONE=0: set RES_TIMEOUT=1 and RES_DATA=0, go to PRESENT.
  - PUF_DONE=1 on the same cycle the counter expires: DONE wins, no timeout.
- CAPTURE: register RES_DATA=PUF_RESPONSE, RES_CHALLENGE=cur, RES_TIMEOUT=0; go to PRESENT.
- PRESENT: RES_VALID=1; RES_CHALLENGE, RES_DATA and RES_TIMEOUT are held stable until the handshake. PUF_RESET=1 during PRESENT.
  - On handshake, cur==end: RES_VALID=0, pulse SWEEP_DONE, go to IDLE.
  - On handshake, cur!=end: cur=cur+1 modulo 2^CW, PUF_CHALLENGE=cur+1, go to ARM.
- Latency:
  - START to first PUF_RESET fall: ARM_CYCLES+1 cycles.
  - PUF_DONE seen in WAIT to RES_VALID: 2 cycles (CAPTURE, then PRESENT).
- Range rules:
  - FIRST==LAST: exactly one result.
  - FIRST>LAST: the sweep wraps through 2^CW-1 to 0; count = 2^CW - FIRST + LAST + 1.
  - FIRST=0, LAST=2^CW-1: full 2^CW results.
  - FIRST/LAST changes after START have no effect until the next sweep.
- START while BUSY=1: ignored, no state change.
- RES_READY held high: one result per challenge, no bubbles skipped, no duplicates.
- RESET mid-sweep: immediate return to reset values; the partial sweep is abandoned and SWEEP_DONE does not fire.

Test Plan:
- FIRST=0x10, LAST=0x13, PUF model asserts DONE 50 cycles after reset fall with response=~challenge, RES_READY=1 -> 4 results (0x10/0xEF, 0x11/0xEE, 0x12/0xED, 0x13/0xEC), RES_TIMEOUT=0, one SWEEP_DONE, BUSY=0 afterwards.
- FIRST=0xFE, LAST=0x01 -> challenges 0xFE, 0xFF, 0x00, 0x01 in order; exactly 4 results.
- TIMEOUT_CYCLES=100, PUF never asserts DONE for challenge 0x05 -> result 0x05/0x00 with RES_TIMEOUT=1 after 100 WAIT cycles; the sweep continues to the next challenge.
- RES_READY toggled pseudo-randomly (30% high) -> RES_VALID never drops before a handshake, payload stable while waiting, no lost or duplicated pairs.
- PUF_DONE stuck high from the previous challenge at SETTLE, then cleared by PUF_RESET -> no premature capture; response taken only after a fresh DONE.
- RESET asserted in WAIT during a 0x00..0x0F sweep, plus START pulsed while BUSY -> outputs return to reset values asynchronously and no SWEEP_DONE fires; the mid-sweep START is ignored and a new START afterwards begins at the new FIRST.
